// File: rtl/tetris_pkg.sv
// tetris_pkg: definitions shared by the Tetris input path.
//   - Button index positions within the 4-bit button / action vectors.
//   - Auto-repeat channel state encoding.
//   - Small elaboration-time helper for counter sizing.
package tetris_pkg;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_ROT   = 2;
  localparam int BTN_DROP  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DELAY  = 2'b01,
    REPEAT = 2'b10,
    HOLD   = 2'b11
  } ch_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_autorepeat_ch.sv
// btn_autorepeat_ch: one auto-repeat channel (FSM plus tick counter).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : game running; 0 parks the channel until a fresh press
//   eff        : effective (already left/right-resolved) button level
//   tick       : one-cycle timebase strobe
//   rep_en     : 1 = auto-repeat while held, 0 = one pulse per press
//   pulse      : registered one-cycle action pulse
module btn_autorepeat_ch
  import tetris_pkg::*;
#(
  parameter int DAS_TICKS = 170,
  parameter int ARR_TICKS = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic eff,
  input  logic tick,
  input  logic rep_en,
  output logic pulse
);

  localparam int CNT_W = $clog2(max2(DAS_TICKS, ARR_TICKS) + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DAS_C    = CNT_W'(DAS_TICKS);
  localparam logic [CNT_W-1:0] ARR_C    = CNT_W'(ARR_TICKS);

  ch_state_e        state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             pulse_r, pulse_s;

  // The counter is cleared on reaching its target, so the increment never wraps.
  assign cnt_inc_s = cnt_r + CNT_ONE;

  // Next-state, next-count and next-pulse decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    pulse_s = 1'b0;
    if (!en) begin
      // A button held through a pause must be released before it can fire.
      state_s = eff ? HOLD : IDLE;
      cnt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (eff) begin
            pulse_s = 1'b1;
            cnt_s   = CNT_ZERO;
            state_s = rep_en ? DELAY : HOLD;
          end else begin
            state_s = IDLE;
          end
        end
        DELAY: begin
          if (!eff) begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
          end else if (tick) begin
            if (cnt_inc_s == DAS_C) begin
              pulse_s = 1'b1;
              state_s = REPEAT;
              cnt_s   = CNT_ZERO;
            end else begin
              cnt_s = cnt_inc_s;
            end
          end else begin
            state_s = DELAY;
          end
        end
        REPEAT: begin
          if (!eff) begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
          end else if (tick) begin
            if (cnt_inc_s == ARR_C) begin
              pulse_s = 1'b1;
              cnt_s   = CNT_ZERO;
            end else begin
              cnt_s = cnt_inc_s;
            end
          end else begin
            state_s = REPEAT;
          end
        end
        HOLD: begin
          if (!eff) begin
            state_s = IDLE;
            cnt_s   = CNT_ZERO;
          end else begin
            state_s = HOLD;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, counter and output pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      pulse_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      pulse_r <= pulse_s;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/btn_autorepeat.sv
// btn_autorepeat: arcade-style auto-repeat for the four game buttons.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   en         : game running enable (0 = paused / game over)
//   btn_lvl    : debounced levels [0]=left [1]=right [2]=rotate [3]=drop
//   act_pulse  : registered one-cycle action pulses, same bit mapping
module btn_autorepeat
  import tetris_pkg::*;
#(
  parameter int         PRESCALE    = 50000,
  parameter int         DAS_TICKS   = 170,
  parameter int         ARR_TICKS   = 50,
  parameter logic [3:0] REPEAT_MASK = 4'b1011
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] btn_lvl,
  output logic [3:0] act_pulse
);

  localparam int PRE_W = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(0);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  logic [PRE_W-1:0] pre_r;
  logic             tick_s;
  logic [3:0]       eff_s;
  logic [3:0]       pulse_s;

  assign tick_s = (pre_r == PRE_LAST);

  // Free-running millisecond prescaler; independent of button activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_r <= PRE_ZERO;
    end else if (tick_s) begin
      pre_r <= PRE_ZERO;
    end else begin
      pre_r <= pre_r + PRE_ONE;
    end
  end

  // Left and right cancel each other; releasing one re-presents the other
  // to its channel as a fresh press.
  always_comb begin
    eff_s            = btn_lvl;
    eff_s[BTN_LEFT]  = btn_lvl[BTN_LEFT]  & ~btn_lvl[BTN_RIGHT];
    eff_s[BTN_RIGHT] = btn_lvl[BTN_RIGHT] & ~btn_lvl[BTN_LEFT];
  end

  for (genvar i = 0; i < 4; i++) begin : g_ch
    btn_autorepeat_ch #(
      .DAS_TICKS(DAS_TICKS),
      .ARR_TICKS(ARR_TICKS)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .eff   (eff_s[i]),
      .tick  (tick_s),
      .rep_en(REPEAT_MASK[i]),
      .pulse (pulse_s[i])
    );
  end

  assign act_pulse = pulse_s;

endmodule

// File: tb/tb_btn_autorepeat.sv
// tb_btn_autorepeat: self-checking bench for btn_autorepeat with a
// behavioural reference model driven by directed and random stimulus.
module tb_btn_autorepeat;

  localparam int         PRESCALE = 4;
  localparam int         DAS      = 3;
  localparam int         ARR      = 2;
  localparam logic [3:0] MASK     = 4'b1011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] btn_lvl = 4'b0000;
  logic [3:0] act_pulse;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  btn_autorepeat #(
    .PRESCALE(PRESCALE),
    .DAS_TICKS(DAS),
    .ARR_TICKS(ARR),
    .REPEAT_MASK(MASK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .btn_lvl(btn_lvl),
    .act_pulse(act_pulse)
  );

  // Reference model: clock edges since reset release, and per button whether
  // a press session is running, whether it must be released first, and how
  // many ticks remain before its next scheduled pulse.
  int         edge_n;
  bit         m_active [4];
  bit         m_blocked[4];
  int         m_left   [4];
  logic [3:0] exp_pulse;

  task automatic model_reset();
    edge_n = 0;
    for (int i = 0; i < 4; i++) begin
      m_active[i] = 1'b0; m_blocked[i] = 1'b0; m_left[i] = 0;
    end
    exp_pulse = 4'b0000;
  endtask

  task automatic model_edge(input logic [3:0] b, input logic e);
    bit tick;
    logic [3:0] eff;
    tick = ((edge_n % PRESCALE) == PRESCALE - 1);
    eff = b;
    eff[0] = b[0] & ~b[1];
    eff[1] = b[1] & ~b[0];
    for (int i = 0; i < 4; i++) begin
      exp_pulse[i] = 1'b0;
      if (!e) begin
        m_active[i] = 1'b0; m_blocked[i] = eff[i];
      end else if (!eff[i]) begin
        m_active[i] = 1'b0; m_blocked[i] = 1'b0;
      end else if (m_blocked[i]) begin
        // held since pause or non-repeating button: silent until release
      end else if (!m_active[i]) begin
        exp_pulse[i] = 1'b1;
        if (MASK[i]) begin
          m_active[i] = 1'b1; m_left[i] = DAS;
        end else begin
          m_blocked[i] = 1'b1;
        end
      end else if (tick) begin
        m_left[i] = m_left[i] - 1;
        if (m_left[i] == 0) begin
          exp_pulse[i] = 1'b1; m_left[i] = ARR;
        end
      end
    end
    edge_n++;
  endtask

  // Drive inputs, advance one clock edge, update the model, settle.
  task automatic cyc(input logic [3:0] b, input logic e);
    btn_lvl = b; en = e;
    @(posedge clk);
    model_edge(b, e);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_lvl = 4'b0000; en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (act_pulse !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_state act_pulse=%b expected=0000", act_pulse);
    end
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 8; c++) begin
      cyc(4'b0000, 1'b1);
      tests_run++;
      if (act_pulse !== 4'b0000) begin
        tests_failed++; $display("FAIL reset_idle c=%0d act_pulse=%b expected=0000", c, act_pulse);
      end
    end
  endtask

  task automatic test_tap();
    int n = 0, first = -1;
    for (int c = 0; c < 105; c++) begin
      cyc((c < 5) ? 4'b0001 : 4'b0000, 1'b1);
      tests_run++;
      if (act_pulse !== exp_pulse) begin
        tests_failed++; $display("FAIL tap_model c=%0d act_pulse=%b expected=%b", c, act_pulse, exp_pulse);
      end
      if (act_pulse[0] === 1'b1) begin
        if (first < 0) first = c;
        n++;
      end
    end
    tests_run++;
    if (n != 1 || first != 0) begin
      tests_failed++; $display("FAIL tap_count pulses=%0d first=%0d expected 1 at 0", n, first);
    end
  endtask

  task automatic test_hold();
    int q[$];
    for (int c = 0; c < 50; c++) begin
      cyc((c < 40) ? 4'b0001 : 4'b0000, 1'b1);
      tests_run++;
      if (act_pulse !== exp_pulse) begin
        tests_failed++; $display("FAIL hold_model c=%0d act_pulse=%b expected=%b", c, act_pulse, exp_pulse);
      end
      if (act_pulse[0] === 1'b1) q.push_back(c);
    end
    tests_run++;
    if (q.size() != 5) begin
      tests_failed++; $display("FAIL hold_count pulses=%0d expected=5", q.size());
    end else begin
      tests_run++;
      if ((q[1] - q[0]) < 9 || (q[1] - q[0]) > 12) begin
        tests_failed++; $display("FAIL hold_das_gap gap=%0d expected 9..12", q[1] - q[0]);
      end
      for (int k = 2; k < 5; k++) begin
        tests_run++;
        if ((q[k] - q[k-1]) != 8) begin
          tests_failed++; $display("FAIL hold_arr_gap k=%0d gap=%0d expected=8", k, q[k] - q[k-1]);
        end
      end
    end
  endtask

  task automatic test_rotate();
    int n = 0;
    for (int c = 0; c < 110; c++) begin
      cyc((c < 100) ? 4'b0100 : 4'b0000, 1'b1);
      tests_run++;
      if (act_pulse !== exp_pulse) begin
        tests_failed++; $display("FAIL rotate_model c=%0d act_pulse=%b expected=%b", c, act_pulse, exp_pulse);
      end
      if (act_pulse[2] === 1'b1) n++;
    end
    tests_run++;
    if (n != 1) begin
      tests_failed++; $display("FAIL rotate_count pulses=%0d expected=1", n);
    end
  endtask

  task automatic test_left_right();
    int n_both = 0;
    logic [3:0] b;
    for (int c = 0; c < 70; c++) begin
      b = (c < 20) ? 4'b0001 : (c < 40) ? 4'b0011 : (c < 60) ? 4'b0010 : 4'b0000;
      cyc(b, 1'b1);
      tests_run++;
      if (act_pulse !== exp_pulse) begin
        tests_failed++; $display("FAIL lr_model c=%0d act_pulse=%b expected=%b", c, act_pulse, exp_pulse);
      end
      if (c >= 20 && c < 40 && act_pulse[1:0] !== 2'b00) n_both++;
      if (c == 40) begin
        tests_run++;
        if (act_pulse[1] !== 1'b1) begin
          tests_failed++; $display("FAIL lr_right_fire act_pulse=%b expected bit1=1", act_pulse);
        end
      end
    end
    tests_run++;
    if (n_both != 0) begin
      tests_failed++; $display("FAIL lr_both_silent pulses=%0d expected=0", n_both);
    end
  endtask

  task automatic test_pause();
    int n = 0;
    for (int c = 0; c < 58; c++) begin
      if (c < 3)       cyc(4'b1000, 1'b1);
      else if (c < 33) cyc(4'b1000, 1'b0);
      else if (c < 53) cyc(4'b1000, 1'b1);
      else if (c < 55) cyc(4'b0000, 1'b1);
      else             cyc(4'b1000, 1'b1);
      tests_run++;
      if (act_pulse !== exp_pulse) begin
        tests_failed++; $display("FAIL pause_model c=%0d act_pulse=%b expected=%b", c, act_pulse, exp_pulse);
      end
      if (c >= 3 && c < 55 && act_pulse[3] === 1'b1) n++;
      if (c == 55) begin
        tests_run++;
        if (act_pulse !== 4'b1000) begin
          tests_failed++; $display("FAIL pause_repress act_pulse=%b expected=1000", act_pulse);
        end
      end
    end
    tests_run++;
    if (n != 0) begin
      tests_failed++; $display("FAIL pause_silent pulses=%0d expected=0", n);
    end
    repeat (5) cyc(4'b0000, 1'b1);
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      cyc(4'b0001, 1'b1);
      if (c > 12 && act_pulse[0] === 1'b1) seen = 1'b1;
    end
    tests_run++;
    if (!seen) begin
      tests_failed++; $display("FAIL resetmid_repeat no repeat pulse seen within 40 cycles");
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (act_pulse !== 4'b0000) begin
      tests_failed++; $display("FAIL resetmid_async act_pulse=%b expected=0000", act_pulse);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    #1;
    tests_run++;
    if (act_pulse !== 4'b0000) begin
      tests_failed++; $display("FAIL resetmid_release act_pulse=%b expected=0000", act_pulse);
    end
    for (int c = 0; c < 25; c++) begin
      cyc((c < 20) ? 4'b0001 : 4'b0000, 1'b1);
      tests_run++;
      if (act_pulse !== exp_pulse) begin
        tests_failed++; $display("FAIL resetmid_model c=%0d act_pulse=%b expected=%b", c, act_pulse, exp_pulse);
      end
      if (c == 0) begin
        tests_run++;
        if (act_pulse !== 4'b0001) begin
          tests_failed++; $display("FAIL resetmid_first act_pulse=%b expected=0001", act_pulse);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] b = 4'b0000;
    logic e = 1'b1;
    int hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        b = 4'($urandom_range(0, 15));
        e = ($urandom_range(0, 7) != 0);
        hold = $urandom_range(1, 30);
      end
      hold--;
      cyc(b, e);
      tests_run++;
      if (act_pulse !== exp_pulse) begin
        tests_failed++; $display("FAIL random_model c=%0d btn=%b en=%b act_pulse=%b expected=%b", c, b, e, act_pulse, exp_pulse);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_tap();
    test_hold();
    test_rotate();
    test_left_right();
    test_pause();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
